// File: rtl/core_state_dump.sv
// Post-run readback engine: streams all 32 registers, then a window of data
// memory, over a valid/ready port while holding the core frozen.
module core_state_dump #(
  parameter int MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_mem_base,
  output logic [4:0]  o_reg_addr,
  input  logic [31:0] i_reg_data,
  output logic        o_mem_rd,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  output logic        o_dump_valid,
  input  logic        i_dump_ready,
  output logic [31:0] o_dump_data,
  output logic        o_dump_is_mem,
  output logic [7:0]  o_dump_idx,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_OUT, S_DONE} state_t;

  localparam logic [7:0] LAST_MEM = 8'(MEM_WORDS - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        phase_mem_q, phase_mem_d;
  logic [31:0] base_q, base_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] dump_data_q, dump_data_d;
  logic        dump_is_mem_q, dump_is_mem_d;
  logic [7:0]  dump_idx_q, dump_idx_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    phase_mem_d   = phase_mem_q;
    base_d        = base_q;
    reg_addr_d    = reg_addr_q;
    mem_addr_d    = mem_addr_q;
    dump_data_d   = dump_data_q;
    dump_is_mem_d = dump_is_mem_q;
    dump_idx_d    = dump_idx_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_RD;
          base_d      = i_mem_base & ~32'h3;
          idx_d       = 8'd0;
          phase_mem_d = 1'b0;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        state_d       = S_OUT;
        dump_data_d   = phase_mem_q ? i_mem_data : i_reg_data;
        dump_is_mem_d = phase_mem_q;
        dump_idx_d    = idx_q;
      end
      S_OUT: begin
        if (i_dump_ready) begin
          if (!phase_mem_q && idx_q == 8'd31) begin
            phase_mem_d = 1'b1;
            idx_d       = 8'd0;
            state_d     = S_RD;
          end else if (phase_mem_q && idx_q == LAST_MEM) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read addresses are registered on entry to RD so they are stable for the
    // whole RD cycle and simply hold afterwards.
    if (state_d == S_RD) begin
      if (phase_mem_d) mem_addr_d = base_d + {22'd0, idx_d, 2'b00};
      else             reg_addr_d = idx_d[4:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 8'd0;
      phase_mem_q   <= 1'b0;
      base_q        <= 32'd0;
      reg_addr_q    <= 5'd0;
      mem_addr_q    <= 32'd0;
      dump_data_q   <= 32'd0;
      dump_is_mem_q <= 1'b0;
      dump_idx_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      phase_mem_q   <= phase_mem_d;
      base_q        <= base_d;
      reg_addr_q    <= reg_addr_d;
      mem_addr_q    <= mem_addr_d;
      dump_data_q   <= dump_data_d;
      dump_is_mem_q <= dump_is_mem_d;
      dump_idx_q    <= dump_idx_d;
    end
  end

  assign o_reg_addr    = reg_addr_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_rd      = (state_q == S_RD) && phase_mem_q;
  assign o_dump_valid  = (state_q == S_OUT);
  assign o_dump_data   = dump_data_q;
  assign o_dump_is_mem = dump_is_mem_q;
  assign o_dump_idx    = dump_idx_q;
  assign o_busy        = (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_OUT);
  assign o_done        = (state_q == S_DONE);

endmodule
